usr_shift_reg: RTL and testbench
================================

// Module: usr_shift_reg
// PURPOSE
//  Parametrised universal register, the clocked multi-bit successor of the single-bit gated D latch.
//  Holds WIDTH bits with complementary outputs q/nq; enable-gated modes: hold, parallel load,
//    logical shift left/right, rotate left/right, clear, set.
//  Reports the bit shifted or rotated out with a one-cycle valid strobe.
//  Used as a datapath register, serialiser and deserialiser in lab designs.
// PARAMETERS
//  WIDTH      8    register width in bits; legal range 2..64
//  RST_VAL    0    value of q after reset; WIDTH bits
// PORTS
//  clk      in   1      rising-edge clock, the only clock
//  rst_n    in   1      reset, synchronous, active-low
//  e        in   1      enable; 0 = hold regardless of mode
//  mode     in   3      operation select; encoding in BEHAVIOUR
//  d        in   WIDTH  parallel load data
//  sin_l    in   1      serial in, enters bit 0 on shift-left
//  sin_r    in   1      serial in, enters bit WIDTH-1 on shift-right
//  q        out  WIDTH  register contents
//  nq       out  WIDTH  bitwise complement of q, always ~q
//  sout     out  1      bit that left the register on the last shift or rotate
//  sout_v   out  1      1-cycle strobe: sout updated on this edge
// BEHAVIOUR
//  - All state changes on the rising clk edge only; no latches; no combinational path from inputs to q.
//  - Reset: rst_n=0 at an edge -> q=RST_VAL, nq=~RST_VAL, sout=0, sout_v=0.
//    Reset overrides e and mode. Asserting rst_n mid-stream discards the operation on that edge.
//  - e=0: q and sout hold; sout_v=0.
//  - e=1: mode decides the next value:
//    000 HOLD : q holds; sout_v=0
//    001 LOAD : q<=d; sout_v=0
//    010 SHL  : q<={q[WIDTH-2:0],sin_l}; sout<=q[WIDTH-1]; sout_v=1
//    011 SHR  : q<={sin_r,q[WIDTH-1:1]}; sout<=q[0]; sout_v=1
//    100 ROL  : q<={q[WIDTH-2:0],q[WIDTH-1]}; sout<=q[WIDTH-1]; sout_v=1
//    101 ROR  : q<={q[0],q[WIDTH-1:1]}; sout<=q[0]; sout_v=1
//    110 CLR  : q<=0; sout_v=0
//    111 SET  : q<={WIDTH{1'b1}}; sout_v=0
//  - Latency: one edge from inputs to q, sout and sout_v. Back-to-back shifts every cycle are legal.
//  - sout_v is 1 only for the cycle after a shift or rotate edge. sout holds its last value otherwise.
//  - Invariant: nq==~q in every cycle, including the reset cycle. nq is derived from the q register
//    (one state register), never a second flop set.
//  - X/undefined mode with e=1 is a verification error; RTL treats it as HOLD.
//  - WIDTH=2 boundary: the shift and rotate slices must elaborate correctly.
// STRUCTURE
//  - Shared package file usr_pkg.vh: 3-bit localparams MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR,
//    MODE_ROL, MODE_ROR, MODE_CLR, MODE_SET. RTL and bench both include it.
//  - One sub-module, usr_cell: a single bit with an 8:1 next-state mux (inputs self, d, left and
//    right neighbours, wrap bit, 0, 1) feeding a synchronous-reset flop, with q/nq outputs.
//  - Top: generate loop of WIDTH usr_cell instances, neighbour and serial wiring, sout/sout_v register.
// TESTING (WIDTH=8, RST_VAL=0 unless stated)
//  - Reset: drive rst_n=0 with e=1 and mode=LOAD, d=8'hFF -> q=8'h00, nq=8'hFF, sout_v=0.
//    Repeat with RST_VAL=8'hA5 -> q=8'hA5.
//  - Load/enable: LOAD d=8'h3C -> q=8'h3C. Then e=0 with mode=CLR for 3 cycles -> q stays 8'h3C.
//  - Shift chain: q=8'h81; SHL with sin_l=0 -> q=8'h02, sout=1, sout_v=1.
//    Next cycle SHR with sin_r=1 -> q=8'h81, sout=0, sout_v=1.
//  - Rotate: q=8'h81, 8 consecutive ROL edges -> q=8'h81, sout_v high for all 8 cycles.
//    ROR once -> q=8'hC0, sout=1.
//  - Reset mid-stream: SHL every cycle, rst_n=0 on the 3rd edge -> q=RST_VAL, sout=0, sout_v=0 that cycle.
//  - Every cycle of every test: assert nq==~q. CLR -> q=8'h00; SET -> q=8'hFF.
//    HOLD or LOAD after a shift -> sout_v=0 and sout unchanged.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared operation encodings for the universal shift register and its bench.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_SET  = 3'b111;

endpackage

// File: rtl/usr_cell.sv
// One bit of the universal register: 8:1 next-state mux into a
// synchronous-reset flop. nq is derived from the single q flop.
module usr_cell
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rst_val,
    input  logic       e,
    input  logic [2:0] mode,
    input  logic       d,
    input  logic       shl_in,
    input  logic       shr_in,
    input  logic       rol_in,
    input  logic       ror_in,
    output logic       q,
    output logic       nq
);

    logic q_nxt;

    // Select the next value of this bit; disabled or unknown modes hold.
    always_comb begin
        q_nxt = q;
        if (e) begin
            case (mode)
                MODE_HOLD: q_nxt = q;
                MODE_LOAD: q_nxt = d;
                MODE_SHL:  q_nxt = shl_in;
                MODE_SHR:  q_nxt = shr_in;
                MODE_ROL:  q_nxt = rol_in;
                MODE_ROR:  q_nxt = ror_in;
                MODE_CLR:  q_nxt = 1'b0;
                MODE_SET:  q_nxt = 1'b1;
                default:   q_nxt = q;
            endcase
        end
    end

    // Storage flop; reset takes priority over any operation on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) q <= rst_val;
        else        q <= q_nxt;
    end

    assign nq = ~q;

endmodule

// File: rtl/usr_shift_reg.sv
// Universal register: WIDTH usr_cell bits with neighbour/serial wiring and
// a registered shift-out bit plus one-cycle valid strobe.
module usr_shift_reg
    import usr_pkg::*;
#(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             e,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             sout,
    output logic             sout_v
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] nq_r;
    logic [WIDTH-1:0] shl_vec;
    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] rol_vec;
    logic [WIDTH-1:0] ror_vec;

    // Per-bit candidate inputs for each shift direction; slices stay legal down to WIDTH=2.
    assign shl_vec = {q_r[WIDTH-2:0], sin_l};
    assign shr_vec = {sin_r, q_r[WIDTH-1:1]};
    assign rol_vec = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
    assign ror_vec = {q_r[0], q_r[WIDTH-1:1]};

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            usr_cell u_cell (
                .clk     (clk),
                .rst_n   (rst_n),
                .rst_val (RST_VAL[i]),
                .e       (e),
                .mode    (mode),
                .d       (d[i]),
                .shl_in  (shl_vec[i]),
                .shr_in  (shr_vec[i]),
                .rol_in  (rol_vec[i]),
                .ror_in  (ror_vec[i]),
                .q       (q_r[i]),
                .nq      (nq_r[i])
            );
        end
    endgenerate

    // Capture the bit leaving the register; the strobe marks only shift/rotate edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sout   <= 1'b0;
            sout_v <= 1'b0;
        end else begin
            sout_v <= 1'b0;
            if (e) begin
                case (mode)
                    MODE_SHL, MODE_ROL: begin
                        sout   <= q_r[WIDTH-1];
                        sout_v <= 1'b1;
                    end
                    MODE_SHR, MODE_ROR: begin
                        sout   <= q_r[0];
                        sout_v <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign q  = q_r;
    assign nq = nq_r;

endmodule

// File: tb/tb_usr_shift_reg.sv
// Bench for usr_shift_reg: three instances (8-bit reset 00, 8-bit reset A5,
// 2-bit reset 01) share one stimulus stream and are compared every cycle
// against an arithmetic model, plus literal expectations on key vectors.
module tb_usr_shift_reg;
    import usr_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       e = 1'b0;
    logic [2:0] mode = MODE_HOLD;
    logic [7:0] d = 8'h00;
    logic       sin_l = 1'b0;
    logic       sin_r = 1'b0;

    logic [7:0] q_a, nq_a, q_b, nq_b;
    logic [1:0] q_c, nq_c;
    logic       so_a, sv_a, so_b, sv_b, so_c, sv_c;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    usr_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut_a (
        .clk(clk), .rst_n(rst_n), .e(e), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q_a), .nq(nq_a), .sout(so_a), .sout_v(sv_a));

    usr_shift_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut_b (
        .clk(clk), .rst_n(rst_n), .e(e), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q_b), .nq(nq_b), .sout(so_b), .sout_v(sv_b));

    usr_shift_reg #(.WIDTH(2), .RST_VAL(2'b01)) dut_c (
        .clk(clk), .rst_n(rst_n), .e(e), .mode(mode), .d(d[1:0]),
        .sin_l(sin_l), .sin_r(sin_r), .q(q_c), .nq(nq_c), .sout(so_c), .sout_v(sv_c));

    // Behavioural model: register value as an integer masked to its width.
    int          mw [3] = '{8, 8, 2};
    logic [63:0] mrv[3] = '{64'h00, 64'hA5, 64'h01};
    logic [63:0] m_q[3];
    logic        m_so[3];
    logic        m_sv[3];

    function automatic logic [65:0] model_next(int w, logic [63:0] rv, logic [63:0] cur,
                                               logic so);
        logic [63:0] mask;
        logic [63:0] nxt;
        logic        nso;
        logic        nsv;
        logic        top;
        logic        bot;
        mask = (64'd1 << w) - 64'd1;
        nxt  = cur;
        nso  = so;
        nsv  = 1'b0;
        top  = cur[w-1];
        bot  = cur[0];
        if (!rst_n) begin
            nxt = rv;
            nso = 1'b0;
        end else if (e) begin
            case (mode)
                MODE_LOAD: nxt = {56'd0, d} & mask;
                MODE_SHL: begin nxt = ((cur << 1) | 64'(sin_l)) & mask; nso = top; nsv = 1'b1; end
                MODE_SHR: begin nxt = (cur >> 1) | (64'(sin_r) << (w - 1)); nso = bot; nsv = 1'b1; end
                MODE_ROL: begin nxt = ((cur << 1) | 64'(top)) & mask; nso = top; nsv = 1'b1; end
                MODE_ROR: begin nxt = (cur >> 1) | (64'(bot) << (w - 1)); nso = bot; nsv = 1'b1; end
                MODE_CLR: nxt = 64'd0;
                MODE_SET: nxt = mask;
                default:  nxt = cur;
            endcase
        end
        return {nsv, nso, nxt};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [65:0] r;
            r = model_next(mw[k], mrv[k], m_q[k], m_so[k]);
            m_q[k]  <= r[63:0];
            m_so[k] <= r[64];
            m_sv[k] <= r[65];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [63:0] aq[3];
            logic [63:0] anq[3];
            logic        aso[3];
            logic        asv[3];
            logic [63:0] mask;
            aq[0] = {56'd0, q_a}; anq[0] = {56'd0, nq_a}; aso[0] = so_a; asv[0] = sv_a;
            aq[1] = {56'd0, q_b}; anq[1] = {56'd0, nq_b}; aso[1] = so_b; asv[1] = sv_b;
            aq[2] = {62'd0, q_c}; anq[2] = {62'd0, nq_c}; aso[2] = so_c; asv[2] = sv_c;
            for (int k = 0; k < 3; k++) begin
                mask = (64'd1 << mw[k]) - 64'd1;
                check($sformatf("model_q[%0d]", k), aq[k], m_q[k]);
                check($sformatf("model_nq[%0d]", k), anq[k], ~m_q[k] & mask);
                check($sformatf("model_sout_v[%0d]", k), 64'(asv[k]), 64'(m_sv[k]));
                check($sformatf("model_sout[%0d]", k), 64'(aso[k]), 64'(m_so[k]));
            end
        end
    end

    // Apply one set of inputs across one rising edge, returning at the next falling edge.
    task automatic step(input logic rn, input logic en, input logic [2:0] md,
                        input logic [7:0] dv, input logic sl, input logic sr);
        rst_n = rn; e = en; mode = md; d = dv; sin_l = sl; sin_r = sr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_q[k] = '0; m_so[k] = 1'b0; m_sv[k] = 1'b0;
        end
        @(negedge clk);

        // Reset overrides an enabled LOAD of all ones.
        step(1'b0, 1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
        chk_en = 1'b1;
        step(1'b0, 1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
        check("rst_q_a", 64'(q_a), 64'h00);
        check("rst_nq_a", 64'(nq_a), 64'hFF);
        check("rst_sv_a", 64'(sv_a), 64'h0);
        check("rst_q_b", 64'(q_b), 64'hA5);
        check("rst_q_c", 64'(q_c), 64'h1);
        check("rst_model_b", m_q[1], 64'hA5);

        // Load, then disabled CLR must hold.
        step(1'b1, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0);
        check("load_q", 64'(q_a), 64'h3C);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, MODE_CLR, 8'h00, 1'b0, 1'b0);
        check("hold_e0_q", 64'(q_a), 64'h3C);
        check("hold_e0_q_b", 64'(q_b), 64'h3C);

        // Shift chain.
        step(1'b1, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
        step(1'b1, 1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
        check("shl_q", 64'(q_a), 64'h02);
        check("shl_sout", 64'(so_a), 64'h1);
        check("shl_sv", 64'(sv_a), 64'h1);
        step(1'b1, 1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
        check("shr_q", 64'(q_a), 64'h81);
        check("shr_sout", 64'(so_a), 64'h0);
        check("shr_sv", 64'(sv_a), 64'h1);
        check("shr_model", m_q[0], 64'h81);

        // Eight rotates return to the start value with the strobe held high.
        step(1'b1, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0);
            check($sformatf("rol_sv_%0d", i), 64'(sv_a), 64'h1);
        end
        check("rol8_q", 64'(q_a), 64'h81);
        step(1'b1, 1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0);
        check("ror_q", 64'(q_a), 64'hC0);
        check("ror_sout", 64'(so_a), 64'h1);

        // HOLD and LOAD after a shift drop the strobe and keep sout.
        step(1'b1, 1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        check("hold_sv", 64'(sv_a), 64'h0);
        check("hold_sout", 64'(so_a), 64'h1);
        check("hold_q", 64'(q_a), 64'hC0);
        step(1'b1, 1'b1, MODE_LOAD, 8'h55, 1'b0, 1'b0);
        check("load_sv", 64'(sv_a), 64'h0);
        check("load_sout", 64'(so_a), 64'h1);

        step(1'b1, 1'b1, MODE_CLR, 8'h00, 1'b0, 1'b0);
        check("clr_q", 64'(q_a), 64'h00);
        step(1'b1, 1'b1, MODE_SET, 8'h00, 1'b0, 1'b0);
        check("set_q", 64'(q_a), 64'hFF);
        check("set_q_c", 64'(q_c), 64'h3);

        // Reset on the third edge of a shift stream.
        step(1'b1, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
        step(1'b1, 1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        check("midrst_q_a", 64'(q_a), 64'h00);
        check("midrst_q_b", 64'(q_b), 64'hA5);
        check("midrst_sout", 64'(so_a), 64'h0);
        check("midrst_sv", 64'(sv_a), 64'h0);
        step(1'b1, 1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        check("post_rst_shl_b", 64'(q_b), 64'h4B);
        check("post_rst_sout_b", 64'(so_b), 64'h1);

        // Mixed directed sweep across all modes, checked by the model each cycle.
        for (int i = 0; i < 48; i++) begin
            step(1'b1, (i % 7) != 3, 3'(i * 5 + i / 8), 8'(i * 37 + 11), i[0], i[1]);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
